// File: rtl/seradd_ctrl.sv
// Sequencer for one single-bit serial adder: latches parallel operands, clears the adder,
// streams bits LSB-first and collects sum/carry. Optional subtract mode: SERADD_CTRL_SUB_EN.
module seradd_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             add_a,
    output logic             add_b,
    output logic             add_cin,
    output logic             add_rst,
    input  logic             add_s,
    input  logic             add_cout,
    output logic [1:0]       dbg_state
);

    // Handshake: start is a level request with no ready; it is accepted on any edge where
    // the FSM is in IDLE or DONE, and dropped silently otherwise. done is a one-cycle pulse.
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_cat;
    logic             cin_q;
    logic [KW-1:0]    k;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign last    = (state == SHIFT) && (k == KW'(WIDTH - 1));
    // Incoming bit lands at the MSB; the collected bits move one place toward the LSB.
    assign sum_cat = {add_s, sum_sr};

`ifdef SERADD_CTRL_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_load   = sub ? ~op_b : op_b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    assign b_load   = op_b;
    assign cin_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            cin_q  <= 1'b0;
            k      <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sr  <= op_a;
                b_sr  <= b_load;
                cin_q <= cin_load;
            end
            if (state == CLEAR) begin
                k <= '0;
            end
            if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= sum_cat[WIDTH-1:1];
                k      <= k + 1'b1;
            end
            if (last) begin
                sum  <= sum_cat;
                cout <= add_cout;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 1'b0;
        add_b     = 1'b0;
        add_cin   = 1'b0;
        add_rst   = rst || (state == CLEAR);
        case (state)
            IDLE: begin
                if (accept) state_nxt = CLEAR;
            end
            CLEAR: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                add_a   = a_sr[0];
                add_b   = b_sr[0];
                add_cin = (k == '0) ? cin_q : 1'b0;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? CLEAR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs read as reset values for the whole time rst is asserted.
        if (rst) begin
            busy    = 1'b0;
            done    = 1'b0;
            add_a   = 1'b0;
            add_b   = 1'b0;
            add_cin = 1'b0;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_seradd_ctrl.sv
// Directed bench for seradd_ctrl at WIDTH=4 with a behavioural serial adder attached.
module tb_seradd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;
    logic       add_a;
    logic       add_b;
    logic       add_cin;
    logic       add_rst;
    logic       add_s;
    logic       add_cout;
    logic [1:0] dbg_state;

    int errors   = 0;
    int checks_n = 0;

    always #5 clk = ~clk;

    seradd_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SERADD_CTRL_SUB_EN
        .sub       (sub),
`endif
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_rst   (add_rst),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .dbg_state (dbg_state)
    );

    // Serial adder model: stored carry flop, cleared by add_rst, c_in ORed into the carry.
    logic c_q;
    logic c_eff;
    always_ff @(posedge clk) c_q <= add_rst ? 1'b0 : add_cout;
    assign c_eff    = c_q | add_cin;
    assign add_s    = add_a ^ add_b ^ c_eff;
    assign add_cout = (add_a & add_b) | (add_a & c_eff) | (add_b & c_eff);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from an idle controller; glitch>0 pulses start with junk operands in that cycle.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic ci, input logic sb, input logic [3:0] exp_s,
                          input logic exp_c, input int glitch);
        int          n;
        logic [31:0] busy_m;
        logic [31:0] rst_m;
        logic [31:0] cin_m;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = ci; sub = sb;
        @(negedge clk);
        start = 1'b0;
        op_a  = 4'($urandom_range(0, 15));
        op_b  = 4'($urandom_range(0, 15));
        cin   = 1'($urandom_range(0, 1));
        n = 1; busy_m = '0; rst_m = '0; cin_m = '0;
        while (!done && n < 20) begin
            busy_m[n] = busy;
            rst_m[n]  = add_rst;
            cin_m[n]  = add_cin;
            if (n == glitch) begin
                start = 1'b1; op_a = 4'hF; op_b = 4'hF; cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, 6);
        check({tag, " sum"}, sum, exp_s);
        check({tag, " cout"}, cout, exp_c);
        check({tag, " busy_cycles"}, busy_m, 32'h3E);
        check({tag, " add_rst_cycles"}, rst_m, 32'h02);
        check({tag, " add_cin_cycles"}, cin_m, (ci | sb) ? 32'h04 : 32'h00);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 1'b0);
        check({tag, " sum_hold"}, sum, exp_s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic done_seen;
        rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst state", dbg_state, 2'd0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst sum", sum, 4'h0);
        check("rst cout", cout, 1'b0);
        check("rst add_a", add_a, 1'b0);
        check("rst add_b", add_b, 1'b0);
        check("rst add_cin", add_cin, 1'b0);
        check("rst add_rst", add_rst, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("idle add_rst", add_rst, 1'b0);

        run_op("1101+1001", 4'b1101, 4'b1001, 1'b0, 1'b0, 4'b0110, 1'b1, 0);
        run_op("1000+0001", 4'b1000, 4'b0001, 1'b0, 1'b0, 4'b1001, 1'b0, 0);
        run_op("1011+1001+c", 4'b1011, 4'b1001, 1'b1, 1'b0, 4'b0101, 1'b1, 0);
        run_op("ignored_start", 4'b0011, 4'b0001, 1'b0, 1'b0, 4'b0100, 1'b0, 3);

        // Reset asserted in SHIFT k=2 discards the operation.
        @(negedge clk);
        start = 1'b1; op_a = 4'b1111; op_b = 4'b0001; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst in_shift", dbg_state, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst state", dbg_state, 2'd0);
        check("midrst sum", sum, 4'h0);
        check("midrst busy", busy, 1'b0);
        check("midrst add_rst", add_rst, 1'b1);
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        check("midrst no_done", done_seen, 1'b0);
        check("midrst sum_after", sum, 4'h0);
        run_op("after_rst 0001+0001", 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b0, 0);

`ifdef SERADD_CTRL_SUB_EN
        run_op("0110-0011", 4'b0110, 4'b0011, 1'b0, 1'b1, 4'b0011, 1'b1, 0);
        run_op("0011-0110", 4'b0011, 4'b0110, 1'b0, 1'b1, 4'b1101, 1'b0, 0);
        sub = 1'b0;
`endif

        // Back-to-back: start held through DONE goes straight to CLEAR.
        @(negedge clk);
        start = 1'b1; op_a = 4'b0101; op_b = 4'b0110; cin = 1'b0;
        @(negedge clk);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b first_latency", n, 6);
        check("b2b first_sum", sum, 4'b1011);
        check("b2b first_cout", cout, 1'b0);
        op_a = 4'b0010; op_b = 4'b0011; cin = 1'b0;
        @(negedge clk);
        n++;
        check("b2b no_idle state", dbg_state, 2'd1);
        check("b2b no_idle add_rst", add_rst, 1'b1);
        check("b2b no_idle busy", busy, 1'b1);
        start = 1'b0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b second_latency", n, 12);
        check("b2b second_sum", sum, 4'b0101);
        check("b2b second_cout", cout, 1'b0);
        @(negedge clk);
        check("b2b back_to_idle", dbg_state, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks_n);
        $finish;
    end

endmodule
